// File: rtl/oled_spi_arbiter.sv
`default_nettype none
// ============================================================================
// oled_spi_arbiter : shares one SPI byte serializer for an SSD1306 Pmod OLED
//                    between a command requester (DC=0) and a pixel-data
//                    requester (DC=1). Optional macro: OLED_ARB_BURST_LIMIT_EN
// Rev 1.0
// ============================================================================
module oled_spi_arbiter #(
  parameter int CLK_DIV   = 1,
  parameter int CS_SETUP  = 1,
  parameter int CS_GAP    = 2,
  parameter int MAX_BURST = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       data_valid,
  input  logic [7:0] data_byte,
  input  logic       data_last,
  output logic       data_ready,
  output logic       busy,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    NEXT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CMD  = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  state_t      state, state_n;
  owner_t      owner, owner_n;
  logic        lock, lock_n;
  logic [7:0]  shreg, shreg_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        phase, phase_n;   // 0 = SCLK low half of a bit, 1 = high half
  logic [15:0] tick, tick_n;     // SETUP/GAP wait counter, SCLK divider in SHIFT
  logic        dc, dc_n;
  logic        take_cmd, take_data;

`ifdef OLED_ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_MAX = 8'((MAX_BURST > 255) ? 255 : MAX_BURST);
  logic [7:0] burst_cnt, burst_cnt_n;
`else
  // MAX_BURST has no effect when a locked burst always runs to data_last.
  if (MAX_BURST < 0) begin : g_max_burst_unused
  end
`endif

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    lock_n     = lock;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    phase_n    = phase;
    tick_n     = tick;
    dc_n       = dc;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
`ifdef OLED_ARB_BURST_LIMIT_EN
    burst_cnt_n = burst_cnt;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready = 1'b1;
        end else if (data_valid) begin
          data_ready = 1'b1;
        end
      end
      SETUP: begin
        if (tick == SETUP_LAST) begin
          state_n   = SHIFT;
          tick_n    = '0;
          phase_n   = 1'b0;
          bit_idx_n = 3'd7;
        end else begin
          tick_n = tick + 16'd1;
        end
      end
      SHIFT: begin
        if (tick != DIV_LAST) begin
          tick_n = tick + 16'd1;
        end else begin
          tick_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else if (bit_idx == 3'd0) begin
            state_n = NEXT;
          end else begin
            phase_n   = 1'b0;
            bit_idx_n = bit_idx - 3'd1;
            shreg_n   = {shreg[6:0], 1'b0};
          end
        end
      end
      NEXT: begin
        if (owner == OWN_CMD) begin
          if (cmd_valid) begin
            cmd_ready = 1'b1;
          end else begin
            state_n = GAP;
            tick_n  = '0;
          end
        end else if (!lock) begin
          state_n = GAP;
          tick_n  = '0;
`ifdef OLED_ARB_BURST_LIMIT_EN
        end else if (burst_cnt >= BURST_MAX && cmd_valid) begin
          // Suspend the burst; lock stays set so IDLE resumes it after the command.
          state_n     = GAP;
          tick_n      = '0;
          burst_cnt_n = '0;
`endif
        end else if (data_valid) begin
          data_ready = 1'b1;
        end
      end
      GAP: begin
        if (tick == GAP_LAST) begin
          state_n = IDLE;
          tick_n  = '0;
        end else begin
          tick_n = tick + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    take_cmd  = cmd_valid && cmd_ready;
    take_data = data_valid && data_ready;

    if (take_cmd || take_data) begin
      state_n   = (state == IDLE) ? SETUP : SHIFT;
      owner_n   = take_cmd ? OWN_CMD : OWN_DATA;
      shreg_n   = take_cmd ? cmd_byte : data_byte;
      dc_n      = take_data;
      tick_n    = '0;
      phase_n   = 1'b0;
      bit_idx_n = 3'd7;
      if (take_data) begin
        lock_n = ~data_last;
      end
    end

`ifdef OLED_ARB_BURST_LIMIT_EN
    if (take_data) begin
      burst_cnt_n = data_last ? 8'd0 :
                    ((burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1);
    end
`endif
  end

  // Pins are registered from the next-state values so they change cleanly with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      lock    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      phase   <= 1'b0;
      tick    <= '0;
      dc      <= 1'b1;
      io_cs   <= 1'b1;
      io_sclk <= 1'b1;
      io_sdin <= 1'b0;
`ifdef OLED_ARB_BURST_LIMIT_EN
      burst_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      lock    <= lock_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      phase   <= phase_n;
      tick    <= tick_n;
      dc      <= dc_n;
      io_cs   <= !(state_n == SETUP || state_n == SHIFT || state_n == NEXT);
      io_sclk <= !(state_n == SHIFT && !phase_n);
      if (state_n == SHIFT) begin
        io_sdin <= shreg_n[7];
      end
`ifdef OLED_ARB_BURST_LIMIT_EN
      burst_cnt <= burst_cnt_n;
`endif
    end
  end

  assign io_dc = dc;
  assign busy  = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/oled_spi_arbiter.md
Name: oled_spi_arbiter

Overview:
Shares one SPI byte serializer for the Pmod OLED (SSD1306-class, 128x32) between two requesters.
- Command requester: init or reconfiguration sequencer; bytes sent with DC=0.
- Pixel-data requester: frame/digit renderer; bytes sent with DC=1.
- Owns CS, DC, SCLK and SDIN. Sits between the display sequencers and the io_* pins.
- Commands have priority. A data burst, once started, holds the bus until its last byte.

Parameters:
CLK_DIV, 1, clk cycles per SCLK half-period (>=1)
CS_SETUP, 1, cycles CS is low before the first SCLK falling edge (>=1)
CS_GAP, 2, cycles CS is held high after releasing the bus (>=1)
MAX_BURST, 128, data bytes before a command may preempt; used only with OLED_ARB_BURST_LIMIT_EN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command byte available
cmd_byte  in  8  command byte
cmd_ready  out  1  command byte accepted this cycle when cmd_valid=1
data_valid  in  1  pixel byte available
data_byte  in  8  pixel byte
data_last  in  1  qualifies data_byte as the final byte of the burst
data_ready  out  1  pixel byte accepted this cycle when data_valid=1
busy  out  1  state != IDLE
io_sclk  out  1  SPI clock, idles high
io_sdin  out  1  SPI data, MSB first
io_cs  out  1  chip select, active low
io_dc  out  1  0 = command, 1 = data

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: io_cs=1, io_sclk=1, io_sdin=0, io_dc=1, busy=0, cmd_ready=0, data_ready=0.
- Reset internals: state=IDLE, owner=none, lock=0, burst count=0.
- Reset mid-transfer takes effect on the next edge. The partial byte is discarded; there is no gap wait.
- Handshake: a transfer occurs on a cycle where valid && ready.
- Ready is combinational. It is asserted only in IDLE or NEXT, and only for the port selected below.
- Byte and DC are captured into the shift register on the accept cycle.
- IDLE: io_cs=1.
  - cmd_valid has priority: owner=CMD, cmd_ready=1.
  - Else if data_valid: owner=DATA, data_ready=1, lock=~data_last.
  - On accept -> SETUP.
- SETUP: io_cs=0, io_dc set by owner. After CS_SETUP cycles -> SHIFT.
- SHIFT: bits 7..0. Each bit is CLK_DIV cycles with io_sclk=0 and io_sdin=bit, then CLK_DIV cycles with io_sclk=1.
  - The byte takes 16*CLK_DIV cycles.
  - After bit 0's high phase -> NEXT.
- NEXT: one decision cycle per visit; io_cs stays 0, io_sclk=1.
  - Owner CMD, cmd_valid=1: accept and -> SHIFT (no CS toggle). Otherwise -> GAP.
  - Owner DATA, lock=1, data_valid=1: accept, lock=~data_last, -> SHIFT.
  - Owner DATA, lock=1, data_valid=0: stay in NEXT with CS held low (stall). cmd_valid is ignored.
  - Owner DATA, lock=0: -> GAP. A pending data_valid for a new burst is not accepted here.
- GAP: io_cs=1. After CS_GAP cycles -> IDLE, which re-arbitrates.
- Simultaneous cmd_valid and data_valid in IDLE: command wins. Data waits with data_ready=0.
- io_sdin holds its last value outside SHIFT.
- io_dc holds its last value while CS is high.
- Timing, single command, default parameters:
  - accept cycle 0, SETUP cycle 1, SHIFT cycles 2-17, NEXT cycle 18, GAP cycles 19-20, IDLE cycle 21.
  - busy=1 on cycles 1-20.

Optional Feature:
OLED_ARB_BURST_LIMIT_EN
- Defined:
  - An 8-bit counter counts bytes accepted within the locked data burst.
  - In NEXT with owner DATA, count>=MAX_BURST and cmd_valid=1: -> GAP with lock kept (burst suspended) and count cleared.
  - IDLE serves commands first.
  - In IDLE with lock=1 and cmd_valid=0, data is granted. data_ready behaves as for a normal grant, and lock stays set until data_last is accepted.
- Undefined: no counter. MAX_BURST is ignored. Commands wait until data_last.

Test Plan:
- Reset, then cmd_byte=0xAE with cmd_valid pulsed at cycle 0:
  - cmd_ready=1 at cycle 0; io_cs falls at cycle 1.
  - io_sdin sampled on the 8 rising edges = 1,0,1,0,1,1,1,0; io_dc=0.
  - io_cs=1 from cycle 19; busy=0 at cycle 21.
- Back-to-back commands 0x81,0x7F with cmd_valid held: 32 SCLK edges under one CS-low window; second cmd_ready exactly at NEXT (cycle 18).
- Data burst 0xFF,0x00,0x3C (data_last on 0x3C) with cmd_valid raised during byte 2:
  - io_dc=1 throughout; no command is accepted until after the GAP that follows 0x3C.
  - Then 0x?? is sent with io_dc=0.
- cmd_valid and data_valid both asserted in IDLE: cmd_ready=1, data_ready=0; the data byte goes out only after the command and its gap.
- Data stall: data_valid drops for 10 cycles mid-burst: FSM stays in NEXT, io_cs=0, io_sclk=1; resumes on data_valid without a CS pulse.
- rst asserted at cycle 9 during SHIFT: next cycle io_cs=1, io_sclk=1, busy=0. With OLED_ARB_BURST_LIMIT_EN and MAX_BURST=4, a 10-byte locked burst plus pending cmd_valid: after 4 bytes CS rises, the command is sent, then bytes 5-10 continue.
